// File: rtl/phv_field_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : phv_field_writeback                                          |
// | Description : Writes match/action result values back into PHV containers.  |
// |               PHVs wait in a small circular FIFO while the lookup runs.    |
// |               Each update merges into the oldest held PHV, or into the     |
// |               incoming PHV directly when the FIFO is empty.                |
// | Options     : WB_STATS_EN - adds drop_cnt/orphan_cnt saturating counters.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module phv_field_writeback #(
  parameter int PHV_LEN = 48*8+32*8+16*8+5*20+256,
  parameter int VAL_LEN = 48*2+32*2+16*2,
  parameter int CFG_LEN = 6*3+6,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHV_LEN-1:0] phv_in,
  input  logic               phv_valid_in,
  output logic               phv_ready_out,
  input  logic [VAL_LEN-1:0] upd_in,
  input  logic               upd_valid_in,
  input  logic [CFG_LEN-1:0] wb_cfg_in,
  input  logic               wb_cfg_valid_in,
  output logic [PHV_LEN-1:0] phv_out,
  output logic               phv_valid_out
`ifdef WB_STATS_EN
  ,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        orphan_cnt
`endif
);

  localparam int DEPTH  = 1 << FIFO_AW;
  // Bit offsets (from the PHV MSB) where each container group starts.
  localparam int B4_OFS = 48*8;
  localparam int B2_OFS = 48*8 + 32*8;
  localparam logic [FIFO_AW:0]   OCC_FULL = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   OCC_ONE  = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

  logic [CFG_LEN-1:0] cfg_q;
  logic [PHV_LEN-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   occ;

  logic               empty;
  logic               full;
  logic               pop;
  logic               bypass;
  logic               push;
  logic               merge_fire;
  logic [PHV_LEN-1:0] merge_src;
  logic [PHV_LEN-1:0] merged;

  // Per-slot views of the config register and the update vector.
  logic [2:0]  slot_idx [6];
  logic [5:0]  slot_en;
  logic [47:0] slot6 [2];
  logic [31:0] slot4 [2];
  logic [15:0] slot2 [2];

  for (genvar s = 0; s < 6; s++) begin : g_cfg
    assign slot_idx[s] = cfg_q[CFG_LEN-1-3*s -: 3];
    assign slot_en[s]  = cfg_q[5-s];
  end

  for (genvar k = 0; k < 2; k++) begin : g_slots
    assign slot6[k] = upd_in[VAL_LEN-1-48*k -: 48];
    assign slot4[k] = upd_in[VAL_LEN-1-96-32*k -: 32];
    assign slot2[k] = upd_in[VAL_LEN-1-160-16*k -: 16];
  end

  assign empty         = (occ == '0);
  assign full          = (occ == OCC_FULL);
  assign phv_ready_out = ~full;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop        = upd_valid_in & ~empty;
  assign bypass     = upd_valid_in & empty & phv_valid_in;
  assign push       = phv_valid_in & ~bypass & (~full | pop);
  assign merge_fire = pop | bypass;
  assign merge_src  = empty ? phv_in : mem[rd_ptr];

  // Overlay enabled slots onto the source PHV; odd slots are applied after
  // their even partner so they win when both target the same container.
  always_comb begin
    merged = merge_src;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (slot_en[k] && slot_idx[k] == 3'(i))
          merged[PHV_LEN-48*(i+1) +: 48] = slot6[k];
        if (slot_en[2+k] && slot_idx[2+k] == 3'(i))
          merged[PHV_LEN-B4_OFS-32*(i+1) +: 32] = slot4[k];
        if (slot_en[4+k] && slot_idx[4+k] == 3'(i))
          merged[PHV_LEN-B2_OFS-16*(i+1) +: 16] = slot2[k];
      end
    end
  end

  // Write-back configuration register; takes effect on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else if (wb_cfg_valid_in) begin
      cfg_q <= wb_cfg_in;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= phv_in;
    end
  end

  // FIFO pointers and occupancy; reset discards everything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Registered output; data holds its last value between merges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_out       <= '0;
      phv_valid_out <= 1'b0;
    end else begin
      phv_valid_out <= merge_fire;
      if (merge_fire) phv_out <= merged;
    end
  end

`ifdef WB_STATS_EN
  logic drop;
  logic orphan;

  assign drop   = phv_valid_in & full & ~pop;
  assign orphan = upd_valid_in & empty & ~phv_valid_in;

  // Saturating event counters for dropped PHVs and orphaned updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt   <= '0;
      orphan_cnt <= '0;
    end else begin
      if (drop && drop_cnt != 16'hFFFF)     drop_cnt   <= drop_cnt + 16'd1;
      if (orphan && orphan_cnt != 16'hFFFF) orphan_cnt <= orphan_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
